// File: rtl/hazard_ctrl_v2.sv
// Hazard and forwarding controller for the 5-stage pipeline: stall/flush arbitration,
// D/E forwarding selects, mul/div stall sequencing and a saturating stall-cycle counter.
module hazard_ctrl_v2 #(
    parameter int REG_W    = 7,
    parameter int MD_DRAIN = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             exc_flush,
    input  logic             exc_stall,
    input  logic             mem_stall,
    input  logic             branch_d,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] wreg_e,
    input  logic [REG_W-1:0] wreg_m,
    input  logic [REG_W-1:0] wreg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memread_e,
    input  logic             memread_m,
    input  logic             md_req,
    input  logic             md_done,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             stall_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic [1:0]       fwd_a_d,
    output logic [1:0]       fwd_b_d,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DCNT_W = (MD_DRAIN > 1) ? $clog2(MD_DRAIN) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_INIT =
        (MD_DRAIN > 0) ? DCNT_W'(MD_DRAIN - 1) : {DCNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r, state_nx_s;
    logic [DCNT_W-1:0] dcnt_r, dcnt_nx_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              load_use_s;
    logic [4:0]        stall_v_s;   // {f, d, e, m, w}
    logic [3:0]        flush_v_s;   // {d, e, m, w}
    logic [1:0]        fwd_a_d_s, fwd_b_d_s, fwd_a_e_s, fwd_b_e_s;

    // Register index 0 is hardwired zero and never matches a producer.
    function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src,
                                       input logic             we);
        return we && (dst == src) && (dst != {REG_W{1'b0}});
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [REG_W-1:0] src,
                                             input logic [REG_W-1:0] wm,
                                             input logic [REG_W-1:0] ww,
                                             input logic             wem,
                                             input logic             rdm,
                                             input logic             wew);
        if (reg_match(wm, src, wem) && !rdm) return 2'b10;
        else if (reg_match(ww, src, wew))    return 2'b01;
        else                                 return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [REG_W-1:0] src,
                                             input logic [REG_W-1:0] we_idx,
                                             input logic [REG_W-1:0] wm_idx,
                                             input logic             rwe,
                                             input logic             rwm,
                                             input logic             rde,
                                             input logic             rdm,
                                             input logic             br);
        if (!br)                                      return 2'b00;
        else if (reg_match(we_idx, src, rwe) && !rde) return 2'b01;
        else if (reg_match(wm_idx, src, rwm) && !rdm) return 2'b10;
        else                                          return 2'b00;
    endfunction

    // Forwarding selects and load-use detection, independent of stall arbitration.
    always_comb begin
        fwd_a_e_s  = fwd_e_sel(rs_e, wreg_m, wreg_w, regwrite_m, memread_m, regwrite_w);
        fwd_b_e_s  = fwd_e_sel(rt_e, wreg_m, wreg_w, regwrite_m, memread_m, regwrite_w);
        fwd_a_d_s  = fwd_d_sel(rs_d, wreg_e, wreg_m, regwrite_e, regwrite_m,
                               memread_e, memread_m, branch_d);
        fwd_b_d_s  = fwd_d_sel(rt_d, wreg_e, wreg_m, regwrite_e, regwrite_m,
                               memread_e, memread_m, branch_d);
        load_use_s = (memread_e && (reg_match(wreg_e, rs_d, regwrite_e) ||
                                    reg_match(wreg_e, rt_d, regwrite_e))) ||
                     (branch_d && memread_m && (reg_match(wreg_m, rs_d, regwrite_m) ||
                                                reg_match(wreg_m, rt_d, regwrite_m)));
    end

    // Mul/div FSM state and drain counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            dcnt_r  <= {DCNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            dcnt_r  <= dcnt_nx_s;
        end
    end

    // Next-state logic; exceptions abort the sequence, memory wait states freeze it.
    always_comb begin
        state_nx_s = state_r;
        dcnt_nx_s  = dcnt_r;
        if (exc_flush || exc_stall) begin
            state_nx_s = ST_IDLE;
            dcnt_nx_s  = {DCNT_W{1'b0}};
        end else if (mem_stall) begin
            state_nx_s = state_r;
            dcnt_nx_s  = dcnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (md_req && !md_done) state_nx_s = ST_BUSY;
                    else                    state_nx_s = ST_IDLE;
                end
                ST_BUSY: begin
                    if (md_done) begin
                        if (MD_DRAIN == 0) begin
                            state_nx_s = ST_IDLE;
                        end else begin
                            state_nx_s = ST_DRAIN;
                            dcnt_nx_s  = DRAIN_INIT;
                        end
                    end else begin
                        state_nx_s = ST_BUSY;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt_r == {DCNT_W{1'b0}}) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        dcnt_nx_s  = dcnt_r - DCNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    dcnt_nx_s  = {DCNT_W{1'b0}};
                end
            endcase
        end
    end

    // Stall/flush arbitration; only the highest-priority source drives the controls.
    always_comb begin
        stall_v_s = 5'b00000;
        flush_v_s = 4'b0000;
        if (!resetn) begin
            stall_v_s = 5'b00000;
            flush_v_s = 4'b0000;
        end else if (exc_flush) begin
            flush_v_s = 4'b1111;
        end else if (exc_stall) begin
            stall_v_s = 5'b11111;
            flush_v_s = 4'b1111;
        end else if (mem_stall) begin
            stall_v_s = 5'b11110;
            flush_v_s = 4'b0001;
        end else if (state_r == ST_BUSY) begin
            stall_v_s = 5'b11100;
            flush_v_s = 4'b0010;
        end else if (state_r == ST_DRAIN || load_use_s) begin
            stall_v_s = 5'b11000;
            flush_v_s = 4'b0100;
        end else begin
            stall_v_s = 5'b00000;
            flush_v_s = 4'b0000;
        end
    end

    assign {stall_f, stall_d, stall_e, stall_m, stall_w} = stall_v_s;
    assign {flush_d, flush_e, flush_m, flush_w}          = flush_v_s;
    assign fwd_a_d   = resetn ? fwd_a_d_s : 2'b00;
    assign fwd_b_d   = resetn ? fwd_b_d_s : 2'b00;
    assign fwd_a_e   = resetn ? fwd_a_e_s : 2'b00;
    assign fwd_b_e   = resetn ? fwd_b_e_s : 2'b00;
    assign md_busy   = resetn && (state_r != ST_IDLE);
    assign stall_cnt = stall_cnt_r;

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_v_s[4] && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed self-checking bench for hazard_ctrl_v2 (MD_DRAIN=2, 5-bit stall counter).
module tb_hazard_ctrl_v2;

    localparam int REG_W = 7;
    localparam int CNT_W = 5;

    logic             clk, resetn;
    logic             exc_flush, exc_stall, mem_stall, branch_d;
    logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic             regwrite_e, regwrite_m, regwrite_w, memread_e, memread_m;
    logic             md_req, md_done;
    logic             stall_f, stall_d, stall_e, stall_m, stall_w;
    logic             flush_d, flush_e, flush_m, flush_w;
    logic [1:0]       fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_v2 #(.REG_W(REG_W), .MD_DRAIN(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .exc_flush(exc_flush), .exc_stall(exc_stall), .mem_stall(mem_stall),
        .branch_d(branch_d),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memread_e(memread_e), .memread_m(memread_m),
        .md_req(md_req), .md_done(md_done),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .stall_w(stall_w),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        exc_flush = 1'b0; exc_stall = 1'b0; mem_stall = 1'b0; branch_d = 1'b0;
        rs_d = 7'd0; rt_d = 7'd0; rs_e = 7'd0; rt_e = 7'd0;
        wreg_e = 7'd0; wreg_m = 7'd0; wreg_w = 7'd0;
        regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        memread_e = 1'b0; memread_m = 1'b0; md_req = 1'b0; md_done = 1'b0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        exc_stall = 1'b1; rs_e = 7'd5; wreg_w = 7'd5; regwrite_w = 1'b1;
        #1;
        chk("rst_stall_f", 32'(stall_f), 32'd0);
        chk("rst_flush_w", 32'(flush_w), 32'd0);
        chk("rst_fwd_a_e", 32'(fwd_a_e), 32'd0);
        repeat (2) next_cycle();
        clear_inputs();
        resetn = 1'b1;
        #1;
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);

        // E-stage forwarding priority and zero register
        next_cycle();
        regwrite_m = 1'b1; wreg_m = 7'd5; regwrite_w = 1'b1; wreg_w = 7'd5; rs_e = 7'd5;
        #1 chk("fwd_e_m_over_w", 32'(fwd_a_e), 32'd2);
        next_cycle();
        wreg_m = 7'd0;
        #1 chk("fwd_e_w", 32'(fwd_a_e), 32'd1);
        next_cycle();
        rs_e = 7'd0; wreg_w = 7'd0;
        #1 chk("fwd_e_zero", 32'(fwd_a_e), 32'd0);
        next_cycle();
        wreg_m = 7'd6; memread_m = 1'b1; wreg_w = 7'd6; rt_e = 7'd6;
        #1 chk("fwd_b_e_load_in_m", 32'(fwd_b_e), 32'd1);
        chk("fwd_d_no_branch", 32'(fwd_a_d), 32'd0);

        // Load-use stall for one cycle, then gone once load is in M without a branch
        next_cycle();
        clear_inputs();
        memread_e = 1'b1; regwrite_e = 1'b1; wreg_e = 7'd3; rt_d = 7'd3;
        #1;
        chk("lu_stall_f", 32'(stall_f), 32'd1);
        chk("lu_stall_d", 32'(stall_d), 32'd1);
        chk("lu_flush_e", 32'(flush_e), 32'd1);
        chk("lu_stall_e", 32'(stall_e), 32'd0);
        next_cycle();
        clear_inputs();
        memread_m = 1'b1; regwrite_m = 1'b1; wreg_m = 7'd3; rt_d = 7'd3;
        #1;
        chk("lu_after_stall_f", 32'(stall_f), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // Branch in D after a load in M
        next_cycle();
        clear_inputs();
        branch_d = 1'b1; memread_m = 1'b1; regwrite_m = 1'b1; wreg_m = 7'd8; rs_d = 7'd8;
        #1;
        chk("br_lu_stall_f", 32'(stall_f), 32'd1);
        chk("br_lu_flush_e", 32'(flush_e), 32'd1);
        next_cycle();
        memread_m = 1'b0;
        #1;
        chk("br_fwd_m", 32'(fwd_a_d), 32'd2);
        chk("br_no_stall", 32'(stall_f), 32'd0);
        chk("br_cnt", 32'(stall_cnt), 32'd2);
        next_cycle();
        regwrite_e = 1'b1; wreg_e = 7'd8; rt_d = 7'd8;
        #1;
        chk("br_fwd_e_newest", 32'(fwd_a_d), 32'd1);
        chk("br_fwd_b_e", 32'(fwd_b_d), 32'd1);

        // Mul/div: md_req at t, md_done at t+4
        next_cycle();
        clear_inputs();
        md_req = 1'b1;
        #1;
        chk("md_t_busy", 32'(md_busy), 32'd0);
        chk("md_t_stall", 32'(stall_f), 32'd0);
        next_cycle();
        md_req = 1'b0;
        #1;
        chk("md_t1_busy", 32'(md_busy), 32'd1);
        chk("md_t1_stall_e", 32'(stall_e), 32'd1);
        chk("md_t1_flush_m", 32'(flush_m), 32'd1);
        for (int i = 2; i <= 3; i++) begin
            next_cycle();
            #1 chk("md_busy_stall_f", 32'(stall_f), 32'd1);
        end
        next_cycle();
        md_done = 1'b1;
        #1 chk("md_t4_stall_e", 32'(stall_e), 32'd1);
        next_cycle();
        md_done = 1'b0;
        #1;
        chk("md_t5_flush_e", 32'(flush_e), 32'd1);
        chk("md_t5_stall_e", 32'(stall_e), 32'd0);
        chk("md_t5_busy", 32'(md_busy), 32'd1);
        next_cycle();
        #1 chk("md_t6_stall_f", 32'(stall_f), 32'd1);
        next_cycle();
        #1;
        chk("md_t7_busy", 32'(md_busy), 32'd0);
        chk("md_t7_stall_f", 32'(stall_f), 32'd0);
        chk("md_cnt", 32'(stall_cnt), 32'd8);

        // md_req with md_done already high stays idle
        next_cycle();
        md_req = 1'b1; md_done = 1'b1;
        #1 chk("md_fast_stall", 32'(stall_f), 32'd0);
        next_cycle();
        clear_inputs();
        #1 chk("md_fast_idle", 32'(md_busy), 32'd0);

        // exc_flush (with mem_stall) during BUSY
        next_cycle();
        md_req = 1'b1;
        next_cycle();
        md_req = 1'b0;
        #1 chk("xf_busy", 32'(md_busy), 32'd1);
        next_cycle();
        exc_flush = 1'b1; mem_stall = 1'b1;
        #1;
        chk("xf_flush_d", 32'(flush_d), 32'd1);
        chk("xf_flush_w", 32'(flush_w), 32'd1);
        chk("xf_stall_f", 32'(stall_f), 32'd0);
        chk("xf_stall_m", 32'(stall_m), 32'd0);
        next_cycle();
        clear_inputs();
        #1 chk("xf_idle", 32'(md_busy), 32'd0);

        // mem_stall during DRAIN freezes the drain counter
        next_cycle();
        md_req = 1'b1;
        next_cycle();
        md_req = 1'b0; md_done = 1'b1;
        #1 chk("ms_busy", 32'(md_busy), 32'd1);
        next_cycle();
        md_done = 1'b0; mem_stall = 1'b1;
        #1;
        chk("ms_stall_m", 32'(stall_m), 32'd1);
        chk("ms_flush_w", 32'(flush_w), 32'd1);
        chk("ms_flush_e", 32'(flush_e), 32'd0);
        next_cycle();
        #1 chk("ms_hold_busy", 32'(md_busy), 32'd1);
        next_cycle();
        mem_stall = 1'b0;
        #1;
        chk("ms_drain1_flush_e", 32'(flush_e), 32'd1);
        chk("ms_drain1_busy", 32'(md_busy), 32'd1);
        next_cycle();
        #1 chk("ms_drain0_busy", 32'(md_busy), 32'd1);
        next_cycle();
        #1;
        chk("ms_idle", 32'(md_busy), 32'd0);
        chk("ms_cnt", 32'(stall_cnt), 32'd14);

        // Global freeze, then counter saturation
        next_cycle();
        exc_stall = 1'b1;
        #1;
        chk("xs_stall_w", 32'(stall_w), 32'd1);
        chk("xs_flush_d", 32'(flush_d), 32'd1);
        chk("xs_stall_f", 32'(stall_f), 32'd1);
        next_cycle();
        exc_stall = 1'b0;
        #1 chk("xs_cnt", 32'(stall_cnt), 32'd15);
        next_cycle();
        exc_stall = 1'b1;
        repeat (20) next_cycle();
        exc_stall = 1'b0;
        #1 chk("cnt_saturate", 32'(stall_cnt), 32'd31);

        // Asynchronous reset in the middle of BUSY
        next_cycle();
        md_req = 1'b1;
        next_cycle();
        md_req = 1'b0;
        #1 chk("rb_busy", 32'(md_busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rb_idle", 32'(md_busy), 32'd0);
        chk("rb_stall_f", 32'(stall_f), 32'd0);
        chk("rb_cnt", 32'(stall_cnt), 32'd0);
        next_cycle();
        resetn = 1'b1;
        #1 chk("rb_after", 32'(md_busy), 32'd0);

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_v2.md
# hazard_ctrl_v2

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W). It produces per-stage stall/flush controls and D- and E-stage forwarding selects. It sequences multi-cycle mul/div stalls through a state machine with a configurable drain length, and handles memory-stage wait states. A saturating stall-cycle counter is provided for performance debug.

## Interface
Parameters:
- REG_W, 7, register index width (GPR plus HI/LO/CP0 extension space); index 0 never forwarded or matched
- MD_DRAIN, 2, bubble cycles inserted after md_done (0 allowed: no drain state)
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  reset; asynchronous, active-low
- exc_flush  in  1  exception/eret redirect this cycle
- exc_stall  in  1  exception unit requests global freeze
- mem_stall  in  1  M-stage memory access not complete
- branch_d  in  1  instruction in D is a branch/jump-register
- rs_d, rt_d, rs_e, rt_e  in  REG_W  source indices in D and E
- wreg_e, wreg_m, wreg_w  in  REG_W  destination indices
- regwrite_e, regwrite_m, regwrite_w  in  1  destination valid
- memread_e, memread_m  in  1  stage holds a load
- md_req  in  1  E holds a mul/div needing multiple cycles
- md_done  in  1  mul/div unit result ready
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1  hold stage register
- flush_d, flush_e, flush_m, flush_w  out  1  load bubble into stage register
- fwd_a_d, fwd_b_d  out  2  D operand select: 00 regfile, 01 E result, 10 M result
- fwd_a_e, fwd_b_e  out  2  E operand select: 00 pipe, 01 W result, 10 M result
- md_busy  out  1  FSM not IDLE
- stall_cnt  out  CNT_W  cycles with stall_f=1, saturating

## Operation
- Match(x,y) means x==y, x!=0, and the producer's regwrite is set.
- E forwarding, newest first: Match(wreg_m,rs_e) and !memread_m -> 10; else Match(wreg_w,rs_e) -> 01; else 00. Same rule for rt_e / fwd_b_e.
- D forwarding (only when branch_d=1, else 00):
  - Match(wreg_e,rs_d) and !memread_e -> 01
  - else Match(wreg_m,rs_d) and !memread_m -> 10
  - else 00
  - Same rule for rt_d.
- Load-use, raised if either holds:
  - memread_e and Match(wreg_e, rs_d or rt_d)
  - branch_d and memread_m and Match(wreg_m, rs_d or rt_d)
  - Response: stall_f, stall_d, flush_e.
- FSM states:
  - IDLE
    - md_req and !md_done -> BUSY
  - BUSY
    - outputs: stall_f, stall_d, stall_e, flush_m
    - md_done -> DRAIN with cnt=MD_DRAIN-1; if MD_DRAIN=0, go to IDLE
  - DRAIN
    - outputs: stall_f, stall_d, flush_e
    - cnt decrements each cycle; cnt==0 -> IDLE
- Priority, highest first (only the winner drives stall/flush; forwarding is always computed):
  1. exc_flush: flush_d/e/m/w=1, no stalls, FSM -> IDLE
  2. exc_stall: all stall_*=1 and all flush_*=1, FSM -> IDLE
  3. mem_stall: stall_f/d/e/m=1, flush_w=1, FSM and cnt hold
  4. FSM BUSY/DRAIN
  5. load-use
  6. none
- stall_cnt increments when stall_f=1 and holds at all-ones.

## Timing
- All stall/flush/fwd outputs are combinational from the inputs and the registered FSM state, valid in the same cycle.
- State, cnt and stall_cnt update on posedge clk.
- resetn low, asynchronous: state=IDLE, cnt=0, stall_cnt=0. All outputs are forced to 0 while resetn=0.
- Mul/div issued at cycle t (md_req=1, md_done=0): BUSY from t+1. md_done seen at t+k: DRAIN at t+k+1 … t+k+MD_DRAIN, IDLE at t+k+MD_DRAIN+1.
- md_req and md_done both high in IDLE: no stall, stays IDLE.
- exc_flush in the same cycle as mem_stall: exc_flush wins; no stall that cycle.
- resetn asserted mid-BUSY: immediate IDLE; outputs 0.

## Test plan
- Forwarding select: wreg_m=5 (regwrite_m=1, memread_m=0) and wreg_w=5 (regwrite_w=1), rs_e=5 -> fwd_a_e=10. Same with wreg_m=0 -> fwd_a_e=01.
- Zero register: rs_e=0 with a matching W write -> fwd_a_e=00.
- Load-use: memread_e=1, wreg_e=3, rt_d=3 -> stall_f=stall_d=flush_e=1 for one cycle, then 0 once the load is in M with branch_d=0.
- Branch after load in M: branch_d=1, memread_m=1, wreg_m=8, rs_d=8 -> stall_f=stall_d=flush_e=1. With memread_m=0 instead -> fwd_a_d=10 and no stall.
- Mul/div with MD_DRAIN=2: md_req at t, md_done at t+4 -> BUSY outputs at t+1..t+4, DRAIN at t+5..t+6, IDLE at t+7; stall_cnt=6.
- Exception interruption: exc_flush during BUSY -> flush_d/e/m/w=1, md_busy=0 next cycle. mem_stall during DRAIN -> cnt frozen and flush_w=1.
